// File: rtl/burst_rr_arbiter_if.sv
// rtl/burst_rr_arbiter_if.sv - requester/resource bus shared by the burst round-robin arbiter
interface burst_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic                     beat;
  logic [NUM_REQ-1:0]       gnt;
  logic [PTR_W-1:0]         gnt_id;
  logic                     busy;
  logic                     last;
  logic                     xfer_done;

  modport master (
    output req, req_len, beat,
    input  gnt, gnt_id, busy, last, xfer_done
  );

  modport slave (
    input  req, req_len, beat,
    output gnt, gnt_id, busy, last, xfer_done
  );
endinterface

// File: rtl/burst_rr_arbiter.sv
// rtl/burst_rr_arbiter.sv - round-robin arbiter holding each grant for a full burst
// Re-arbitrates on the final beat so back-to-back bursts have no dead cycle.
module burst_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input logic                clk,
  input logic                rst,
  burst_rr_arbiter_if.slave  bus
);
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0]   r_len_q, w_len_q_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [PTR_W-1:0]   r_gnt_id, w_gnt_id_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_xfer_done, w_xfer_done_nxt;

  logic               w_last;
  logic [PTR_W-1:0]   w_base;
  logic [PTR_W-1:0]   w_win;
  logic               w_found;
  logic               w_arb;

  assign w_last = r_busy && (r_cnt == r_len_q);

  // On the final beat the scan starts after the finishing owner, which is where rr_ptr is about to land.
  assign w_base = (r_state == S_BUSY) ? r_gnt_id : r_rr_ptr;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && bus.req[(int'(w_base) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = PTR_W'((int'(w_base) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= PTR_W'(NUM_REQ - 1);
      r_cnt       <= '0;
      r_len_q     <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_busy      <= 1'b0;
      r_xfer_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_len_q     <= w_len_q_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_busy      <= w_busy_nxt;
      r_xfer_done <= w_xfer_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_cnt_nxt       = r_cnt;
    w_len_q_nxt     = r_len_q;
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_busy_nxt      = r_busy;
    w_xfer_done_nxt = 1'b0;
    w_arb           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_found) w_arb = 1'b1;
      end
      S_BUSY: begin
        if (bus.beat) begin
          if (w_last) begin
            w_rr_ptr_nxt    = r_gnt_id;
            w_xfer_done_nxt = 1'b1;
            if (w_found) begin
              w_arb = 1'b1;
            end else begin
              w_gnt_nxt   = '0;
              w_busy_nxt  = 1'b0;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + LEN_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_arb) begin
      w_gnt_nxt    = NUM_REQ'(1) << w_win;
      w_gnt_id_nxt = w_win;
      w_len_q_nxt  = bus.req_len[int'(w_win) * LEN_W +: LEN_W];
      w_cnt_nxt    = '0;
      w_busy_nxt   = 1'b1;
      w_state_nxt  = S_BUSY;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.busy      = r_busy;
  assign bus.last      = w_last;
  assign bus.xfer_done = r_xfer_done;
endmodule

// File: tb/tb_burst_rr_arbiter.sv
// tb/tb_burst_rr_arbiter.sv - directed self-checking bench for burst_rr_arbiter
module tb_burst_rr_arbiter;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  burst_rr_arbiter_if #(.NUM_REQ(4), .LEN_W(4)) bus ();

  burst_rr_arbiter #(.NUM_REQ(4), .LEN_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant must be zero or one-hot and track gnt_id while busy.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.busy ? (bus.gnt !== (4'b0001 << bus.gnt_id)) : (bus.gnt !== 4'b0000)) begin
        errors++;
        $display("FAIL invariant t=%0t gnt=%b gnt_id=%0d busy=%b", $time, bus.gnt, bus.gnt_id, bus.busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 4'b0000;
    bus.req_len = 16'h0000;
    bus.beat = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.req_len = 16'h0000;
    bus.beat = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.gnt, bus.gnt_id, bus.busy, bus.xfer_done, bus.last} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b id=%0d busy=%b xd=%b last=%b want all 0",
               bus.gnt, bus.gnt_id, bus.busy, bus.xfer_done, bus.last);
    end
    checks++;
    if (dut.r_rr_ptr !== 2'd3) begin
      errors++;
      $display("FAIL reset_rr_ptr got %0d want 3", dut.r_rr_ptr);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant got gnt=%b busy=%b want 0001/1", bus.gnt, bus.busy);
    end
  endtask

  task automatic test_single_beat();
    do_reset();
    bus.req = 4'b0100;
    bus.beat = 1'b1;
    tick();
    checks++;
    if (bus.gnt !== 4'b0100 || bus.last !== 1'b1 || bus.xfer_done !== 1'b0) begin
      errors++;
      $display("FAIL single_grant got gnt=%b last=%b xd=%b want 0100/1/0", bus.gnt, bus.last, bus.xfer_done);
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.xfer_done !== 1'b1) begin
      errors++;
      $display("FAIL single_release got gnt=%b busy=%b xd=%b want 0000/0/1", bus.gnt, bus.busy, bus.xfer_done);
    end
    bus.req = 4'b0100;
    tick();
    tick();
    checks++;
    if (bus.gnt !== 4'b0100 || bus.xfer_done !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_regrant got gnt=%b xd=%b busy=%b want 0100/1/1", bus.gnt, bus.xfer_done, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    logic       exp_xd;
    logic       exp_last;
    do_reset();
    bus.req = 4'b1111;
    bus.req_len = 16'h2222;
    bus.beat = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      exp_gnt  = 4'b0001 << ((c / 3) % 4);
      exp_xd   = (c > 0) && (c % 3 == 0);
      exp_last = (c % 3 == 2);
      checks++;
      if ({bus.gnt, bus.xfer_done, bus.last} !== {exp_gnt, exp_xd, exp_last}) begin
        errors++;
        $display("FAIL rr_cycle%0d got gnt=%b xd=%b last=%b want %b/%b/%b",
                 c, bus.gnt, bus.xfer_done, bus.last, exp_gnt, exp_xd, exp_last);
      end
    end
  endtask

  task automatic test_lone_requester();
    logic exp_xd;
    do_reset();
    bus.req = 4'b0010;
    bus.req_len = 16'h1111;
    bus.beat = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_xd = (c > 0) && (c % 2 == 0);
      checks++;
      if ({bus.gnt, bus.busy, bus.xfer_done} !== {4'b0010, 1'b1, exp_xd}) begin
        errors++;
        $display("FAIL lone_cycle%0d got gnt=%b busy=%b xd=%b want 0010/1/%b",
                 c, bus.gnt, bus.busy, bus.xfer_done, exp_xd);
      end
    end
  endtask

  task automatic test_drop_and_gaps();
    // beat pattern after grant, and expected last/gnt after each edge
    logic       beats [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       lasts [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] gnts  [8] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
    do_reset();
    bus.req = 4'b1000;
    bus.req_len = 16'h3000;
    tick();
    bus.req_len = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      bus.beat = beats[i];
      if (i == 1) bus.req = 4'b0000;
      tick();
      checks++;
      if (bus.last !== lasts[i] || bus.gnt !== gnts[i] || bus.xfer_done !== (i == 7)) begin
        errors++;
        $display("FAIL drop_step%0d got gnt=%b last=%b xd=%b want %b/%b/%b",
                 i, bus.gnt, bus.last, bus.xfer_done, gnts[i], lasts[i], (i == 7));
      end
    end
    bus.beat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.gnt, bus.busy, bus.xfer_done, bus.last} !== 7'b0) begin
        errors++;
        $display("FAIL idle_beat%0d got gnt=%b busy=%b xd=%b last=%b want all 0",
                 i, bus.gnt, bus.busy, bus.xfer_done, bus.last);
      end
    end
    bus.beat = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.req = 4'b0100;
    bus.req_len = 16'h0300;
    bus.beat = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (bus.gnt !== 4'b0100 || bus.last !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre got gnt=%b last=%b want 0100/0", bus.gnt, bus.last);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.gnt, bus.gnt_id, bus.busy, bus.xfer_done, bus.last} !== 9'b0) begin
      errors++;
      $display("FAIL midrst_clear got gnt=%b id=%0d busy=%b xd=%b last=%b want all 0",
               bus.gnt, bus.gnt_id, bus.busy, bus.xfer_done, bus.last);
    end
    rst = 1'b0;
    bus.req = 4'b0110;
    bus.beat = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 4'b0010 || bus.gnt_id !== 2'd1 || bus.xfer_done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_next got gnt=%b id=%0d xd=%b want 0010/1/0", bus.gnt, bus.gnt_id, bus.xfer_done);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 4'b0000;
    bus.req_len = 16'h0000;
    bus.beat = 1'b0;
    test_reset();
    test_single_beat();
    test_round_robin();
    test_lone_requester();
    test_drop_and_gaps();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/burst_rr_arbiter.md
# burst_rr_arbiter

Round-robin arbiter that shares one burst-capable resource between `NUM_REQ` requesters. A grant is held for a whole burst of a requester-specified beat count and is released only after the final beat. The next owner is chosen round-robin, starting after the last owner, with back-to-back re-arbitration on the final beat. It sits between requester ports and a shared datapath that pulses `beat` once per completed beat.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `LEN_W`, 4: width of each burst-length field.
- `PTR_W`, `$clog2(NUM_REQ)`: width of the owner index.

- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `req` input NUM_REQ: per-requester request level.
- `req_len` input NUM_REQ*LEN_W: burst length minus 1 per requester. Requester i uses bits [i*LEN_W +: LEN_W].
- `beat` input 1: the resource completed one beat of the current burst.
- `gnt` output NUM_REQ: one-hot grant, registered.
- `gnt_id` output PTR_W: binary index of the owner, registered.
- `busy` output 1: a burst is in progress, registered.
- `last` output 1: the next `beat` completes the burst. Combinational: `busy && cnt == len_q`.
- `xfer_done` output 1: one-cycle pulse, registered, in the cycle after the final beat.

## Operation
- **States:** IDLE and BUSY.
- **Internal registers:**
  - `rr_ptr` (PTR_W): index of the last owner. Reset value NUM_REQ-1, so requester 0 has top priority after reset.
  - `cnt` (LEN_W): beats completed in the current burst.
  - `len_q` (LEN_W): captured length of the current burst.
- **Pick function:** scan indices `rr_ptr+1` … `rr_ptr+NUM_REQ`, modulo NUM_REQ. The first index with `req` set wins.
- **IDLE:**
  - If `|req`: load `gnt`, `gnt_id`, `len_q` (from the winner's `req_len` slice), set `cnt`=0 and `busy`=1, go to BUSY.
  - Otherwise hold all registers.
- **BUSY, `beat && !last`:** `cnt`++.
- **BUSY, `beat && last` (final beat):**
  - `rr_ptr` ← `gnt_id`; `xfer_done`=1 next cycle.
  - Re-arbitrate in the same cycle using the updated pointer, i.e. the pick starts at `gnt_id+1`.
  - If `|req`: load the new owner exactly as from IDLE and stay in BUSY.
  - Otherwise clear `gnt`, set `busy`=0, go to IDLE. `gnt_id` holds its last value.
- **BUSY, no `beat`:** hold all registers.
- **Requests during BUSY:**
  - `req` is not sampled, except on the final-beat cycle.
  - The owner dropping `req` mid-burst does not shorten the burst. The grant persists until the final beat.
- **Re-grant of the just-finished owner:** its `req` is still examined on the final-beat cycle, at lowest priority. It wins again only if no other request is set.
- `beat` while `!busy` is ignored: no counter change, no pulse.
- `req_len` changes after capture have no effect.
- `len`=0 gives a single-beat burst: `last` is high from the first BUSY cycle.
- `rr_ptr` changes only on the final beat. It wraps NUM_REQ-1 → 0 via the modulo scan.

## Timing
- **Reset values:** `gnt`=0, `gnt_id`=0, `busy`=0, `xfer_done`=0, `last`=0, `cnt`=0, `len_q`=0, `rr_ptr`=NUM_REQ-1. State = IDLE.
- **Reset mid-burst:** returns to the reset values on the next edge. No `xfer_done` is issued.
- **Request-to-grant latency:** `req` sampled high at edge N in IDLE → `gnt`/`busy` high after edge N.
- **Burst occupancy:** with `beat` continuous, a burst of length L (`len`=L-1) holds `gnt` for exactly L cycles.
- **Final beat at cycle M:** in cycle M+1, `xfer_done`=1 and `gnt` shows either the new owner or zero. There is no dead cycle between back-to-back bursts.
- **Invariant:** `gnt` is always zero or one-hot, and equals `1<<gnt_id` whenever `busy`=1.

## Test plan
- **Reset:** hold `rst` 2 cycles with `req`=4'b1111 → all outputs 0 and `rr_ptr`=3. The first grant after release is `gnt`=4'b0001.
- **Single beat:** `req`=4'b0100, `len2`=0, `beat` tied high → `gnt`=4'b0100 for 1 cycle, then `gnt`=0 with `xfer_done`=1. `gnt` is 4'b0100 again only if `req2` stays high.
- **Round-robin:** `req`=4'b1111, all `len`=2, `beat` high → grant order 0,1,2,3,0, each held 3 cycles. `xfer_done` pulses every 3rd cycle with no gap.
- **Lone requester:** `req`=4'b0010, `len`=1 → back-to-back bursts to requester 1. `gnt` stays 4'b0010 continuously and `xfer_done` pulses every 2 cycles.
- **Request drop and beat gaps:** owner 3, `len`=3, `req3` drops after beat 1, `beat` has gaps → `gnt` is held until the 4th `beat`. `last` is high only while `cnt`=3. `beat` pulses in IDLE give no response.
- **Reset mid-burst:** `rst` asserted after 2 of 4 beats → `gnt`=0, `busy`=0, no `xfer_done`. The next grant goes to the lowest-index requester.
